// File: rtl/cache_mem_responder.sv
// Bridges cache line/word reads and buffered writes onto a single-port word memory.
// Reads return 2 cycles after acceptance, with one beat per cycle and no backpressure; a pending write blocks new reads.
module cache_mem_responder (
   input  logic         clk_g,
   input  logic         reset,
   input  logic         rd_req,
   input  logic [2:0]   rd_type,
   input  logic [31:0]  rd_addr,
   output logic         rd_rdy,
   output logic         ret_valid,
   output logic         ret_last,
   output logic [31:0]  ret_data,
   input  logic         wr_req,
   input  logic [2:0]   wr_type,
   input  logic [31:0]  wr_addr,
   input  logic [3:0]   wr_wstrb,
   input  logic [127:0] wr_data,
   output logic         wr_rdy,
   output logic         mem_en,
   output logic [3:0]   mem_we,
   output logic [31:0]  mem_addr,
   output logic [31:0]  mem_wdata,
   input  logic [31:0]  mem_rdata
);

   localparam logic [2:0] TYPE_LINE = 3'b100;

   typedef enum logic {R_IDLE, R_BURST} r_state_t;
   typedef enum logic {W_IDLE, W_DRAIN} w_state_t;

   r_state_t r_state, r_next;
   w_state_t w_state, w_next;

   logic [31:2]  rd_addr_q;
   logic         rd_line_q;
   logic [1:0]   issue_cnt;
   logic [1:0]   ret_cnt;
   logic         issue_done;
   logic         ret_pend;

   logic [31:2]  wb_addr_q;
   logic         wb_line_q;
   logic [3:0]   wb_strb_q;
   logic [127:0] wb_data_q;
   logic [1:0]   drain_cnt;

   logic rd_accept, wr_capture;
   logic rd_issue, wr_issue, rd_issue_last, wr_issue_last, ret_final;
   logic [31:0] wb_word;

   // Sub-word lane selection is left to the requester, so the low address bits are never used.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{rd_addr[1:0], wr_addr[1:0]};

   assign wr_rdy     = (w_state == W_IDLE);
   assign rd_rdy     = (r_state == R_IDLE) && (w_state == W_IDLE) && !wr_req;
   assign rd_accept  = rd_req && rd_rdy;
   assign wr_capture = wr_req && wr_rdy;

   // Reads own the memory for the whole burst; the drain only runs while the read side is idle.
   assign rd_issue      = (r_state == R_BURST) && !issue_done;
   assign wr_issue      = (w_state == W_DRAIN) && (r_state == R_IDLE);
   assign rd_issue_last = rd_issue && (!rd_line_q || issue_cnt == 2'd3);
   assign wr_issue_last = wr_issue && (!wb_line_q || drain_cnt == 2'd3);
   assign ret_final     = ret_pend && (!rd_line_q || ret_cnt == 2'd3);

   assign ret_valid = ret_pend;
   assign ret_last  = ret_final;
   assign ret_data  = ret_pend ? mem_rdata : 32'h0;

   always_comb begin
      wb_word = wb_data_q[127:96];
      if (wb_line_q) begin
         case (drain_cnt)
            2'd0: wb_word = wb_data_q[127:96];
            2'd1: wb_word = wb_data_q[95:64];
            2'd2: wb_word = wb_data_q[63:32];
            2'd3: wb_word = wb_data_q[31:0];
         endcase
      end
   end

   always_comb begin
      r_next    = r_state;
      w_next    = w_state;
      mem_en    = 1'b0;
      mem_we    = 4'h0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;

      case (r_state)
         R_IDLE:  if (rd_accept) r_next = R_BURST;
         R_BURST: if (ret_final) r_next = R_IDLE;
      endcase

      case (w_state)
         W_IDLE:  if (wr_capture) w_next = W_DRAIN;
         W_DRAIN: if (wr_issue_last) w_next = W_IDLE;
      endcase

      if (rd_issue) begin
         mem_en   = 1'b1;
         mem_addr = rd_line_q ? {rd_addr_q[31:4], issue_cnt, 2'b00} : {rd_addr_q[31:2], 2'b00};
      end else if (wr_issue) begin
         mem_en    = 1'b1;
         mem_we    = wb_line_q ? 4'hF : wb_strb_q;
         mem_addr  = wb_line_q ? {wb_addr_q[31:4], drain_cnt, 2'b00} : {wb_addr_q[31:2], 2'b00};
         mem_wdata = wb_word;
      end
   end

   always_ff @(posedge clk_g or posedge reset) begin
      if (reset) begin
         r_state    <= R_IDLE;
         rd_addr_q  <= '0;
         rd_line_q  <= 1'b0;
         issue_cnt  <= 2'd0;
         ret_cnt    <= 2'd0;
         issue_done <= 1'b0;
         ret_pend   <= 1'b0;
      end else begin
         r_state  <= r_next;
         ret_pend <= rd_issue;
         if (rd_accept) begin
            rd_addr_q  <= rd_addr[31:2];
            rd_line_q  <= (rd_type == TYPE_LINE);
            issue_cnt  <= 2'd0;
            ret_cnt    <= 2'd0;
            issue_done <= 1'b0;
         end else begin
            if (rd_issue_last)
               issue_done <= 1'b1;
            else if (rd_issue)
               issue_cnt <= issue_cnt + 2'd1;
            if (ret_pend && !ret_final)
               ret_cnt <= ret_cnt + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_g or posedge reset) begin
      if (reset) begin
         w_state   <= W_IDLE;
         wb_addr_q <= '0;
         wb_line_q <= 1'b0;
         wb_strb_q <= 4'h0;
         wb_data_q <= '0;
         drain_cnt <= 2'd0;
      end else begin
         w_state <= w_next;
         if (wr_capture) begin
            wb_addr_q <= wr_addr[31:2];
            wb_line_q <= (wr_type == TYPE_LINE);
            wb_strb_q <= wr_wstrb;
            wb_data_q <= wr_data;
            drain_cnt <= 2'd0;
         end else if (wr_issue && !wr_issue_last) begin
            drain_cnt <= drain_cnt + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: word-memory model, transaction-level reference memory and beat scoreboard.
module tb_cache_mem_responder;

   localparam logic [2:0] T_BYTE = 3'b000;
   localparam logic [2:0] T_HALF = 3'b001;
   localparam logic [2:0] T_WORD = 3'b010;
   localparam logic [2:0] T_LINE = 3'b100;

   logic         clk_g = 1'b0;
   logic         reset;
   logic         rd_req;
   logic [2:0]   rd_type;
   logic [31:0]  rd_addr;
   logic         rd_rdy;
   logic         ret_valid;
   logic         ret_last;
   logic [31:0]  ret_data;
   logic         wr_req;
   logic [2:0]   wr_type;
   logic [31:0]  wr_addr;
   logic [3:0]   wr_wstrb;
   logic [127:0] wr_data;
   logic         wr_rdy;
   logic         mem_en;
   logic [3:0]   mem_we;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;

   always #5 clk_g = ~clk_g;

   cache_mem_responder dut (
      .clk_g(clk_g), .reset(reset),
      .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
      .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
      .wr_data(wr_data), .wr_rdy(wr_rdy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;
   beat_t exp_q[$];

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] data;
   } wr_t;
   wr_t wlog[$];

   typedef struct {
      logic [2:0]   wtype;
      logic [31:0]  waddr;
      logic [3:0]   wstrb;
      logic [127:0] wdata;
      int           nbeats;
      logic [31:0]  addr0;
      logic [3:0]   we;
   } wvec_t;

   logic [31:0] mem_arr [int];
   logic [31:0] ref_mem [int];
   logic [31:0] mem_cur;

   function automatic logic [31:0] init_val(int idx);
      logic [31:0] v;
      v = 32'(idx) * 32'h9E37_79B1;
      return v ^ 32'h5A5A_0F0F;
   endfunction

   // Memory model: one-cycle read latency, byte-enabled writes.
   always @(posedge clk_g) begin
      if (mem_en) begin
         mem_cur = mem_arr.exists(int'(mem_addr[13:2])) ? mem_arr[int'(mem_addr[13:2])]
                                                         : init_val(int'(mem_addr[13:2]));
         if (mem_we == 4'h0) begin
            mem_rdata <= mem_cur;
         end else begin
            for (int i = 0; i < 4; i++)
               if (mem_we[i]) mem_cur[8*i +: 8] = mem_wdata[8*i +: 8];
            mem_arr[int'(mem_addr[13:2])] = mem_cur;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_word(int idx);
      return ref_mem.exists(idx) ? ref_mem[idx] : init_val(idx);
   endfunction

   task automatic ref_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                            input logic [127:0] d);
      logic [31:0] w;
      if (t == T_LINE) begin
         for (int k = 0; k < 4; k++)
            ref_mem[int'(a[13:4]) * 4 + k] = d[127 - 32*k -: 32];
      end else begin
         w = ref_word(int'(a[13:2]));
         for (int i = 0; i < 4; i++)
            if (s[i]) w[8*i +: 8] = d[96 + 8*i +: 8];
         ref_mem[int'(a[13:2])] = w;
      end
   endtask

   task automatic push_expected(input logic [2:0] t, input logic [31:0] a);
      int nb;
      nb = (t == T_LINE) ? 4 : 1;
      for (int k = 0; k < nb; k++) begin
         if (t == T_LINE) exp_q.push_back('{ref_word(int'(a[13:4]) * 4 + k), k == nb - 1});
         else             exp_q.push_back('{ref_word(int'(a[13:2])), 1'b1});
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk_g);
         if (!reset) begin
            if (ret_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", 32'(ret_valid), 32'd0);
               end else begin
                  check("ret_data", ret_data, exp_q[0].data);
                  check("ret_last", 32'(ret_last), 32'(exp_q[0].last));
                  exp_q.delete(0);
               end
            end
            if (mem_en && mem_we != 4'h0) wlog.push_back('{mem_addr, mem_we, mem_wdata});
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_g);
      #1;
   endtask

   task automatic do_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                           input logic [127:0] d);
      int n;
      n = 0;
      while (!wr_rdy && n < 40) begin
         tick();
         n++;
      end
      check("wr_rdy_before_write", 32'(wr_rdy), 32'd1);
      wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
      ref_write(t, a, s, d);
      tick();
      wr_req = 1'b0;
      check("wr_rdy_after_capture", 32'(wr_rdy), 32'd0);
   endtask

   // Waits for acceptance of a read already driven on rd_*, then checks the burst cycle by cycle.
   task automatic finish_read(input logic [2:0] t, input logic [31:0] a, output int waited);
      int nb;
      logic [31:0] ea;
      nb = (t == T_LINE) ? 4 : 1;
      waited = 0;
      @(negedge clk_g);
      while (!rd_rdy && waited < 60) begin
         @(negedge clk_g);
         waited++;
      end
      check("rd_rdy_accept", 32'(rd_rdy), 32'd1);
      @(posedge clk_g);
      #1;
      rd_req = 1'b0;
      for (int c = 0; c <= nb; c++) begin
         @(negedge clk_g);
         ea = (t == T_LINE) ? ({a[31:4], 4'h0} + 32'(4 * c)) : {a[31:2], 2'b00};
         check("rd_mem_en", 32'(mem_en), 32'(c < nb));
         if (c < nb) begin
            check("rd_mem_addr", mem_addr, ea);
            check("rd_mem_we", 32'(mem_we), 32'd0);
         end
         check("ret_valid_timing", 32'(ret_valid), 32'(c > 0));
         check("ret_last_timing", 32'(ret_last), 32'(c == nb));
      end
      tick();
      check("beats_outstanding", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   task automatic do_read(input logic [2:0] t, input logic [31:0] a);
      int w;
      push_expected(t, a);
      rd_req = 1'b1; rd_type = t; rd_addr = a;
      finish_read(t, a, w);
   endtask

   wvec_t tbl[5];
   logic [2:0] type_pick[4];

   initial begin
      int n, act;
      logic [31:0] ra;
      logic [2:0] rt;
      logic [127:0] rd128;

      tbl[0] = '{T_LINE, 32'h2000, 4'h0,
                 {32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003}, 4, 32'h2000, 4'hF};
      tbl[1] = '{T_WORD, 32'h3006, 4'b1100, {32'hAABB_0000, 96'h0}, 1, 32'h3004, 4'b1100};
      tbl[2] = '{T_BYTE, 32'h1003, 4'b1000, {32'h5500_0000, 96'h0}, 1, 32'h1000, 4'b1000};
      tbl[3] = '{T_HALF, 32'h0102, 4'b0011, {32'h0000_BEEF, 96'h0}, 1, 32'h0100, 4'b0011};
      tbl[4] = '{T_LINE, 32'h040C, 4'h5,
                 {32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3}, 4, 32'h0400, 4'hF};
      type_pick[0] = T_BYTE; type_pick[1] = T_HALF; type_pick[2] = T_WORD; type_pick[3] = T_LINE;

      reset = 1'b1; rd_req = 1'b0; rd_type = 3'b0; rd_addr = 32'h0;
      wr_req = 1'b0; wr_type = 3'b0; wr_addr = 32'h0; wr_wstrb = 4'h0; wr_data = '0;
      #3;
      check("rst_rd_rdy", 32'(rd_rdy), 32'd1);
      check("rst_wr_rdy", 32'(wr_rdy), 32'd1);
      check("rst_ret_valid", 32'(ret_valid), 32'd0);
      check("rst_ret_last", 32'(ret_last), 32'd0);
      check("rst_ret_data", ret_data, 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);

      fork
         monitor();
      join_none
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Line read of untouched memory.
      do_read(T_LINE, 32'h0000_1230);

      // Write vectors: drain length, addresses, strobes and data per beat.
      for (int v = 0; v < 5; v++) begin
         wlog.delete();
         do_write(tbl[v].wtype, tbl[v].waddr, tbl[v].wstrb, tbl[v].wdata);
         n = 1;
         while (n < 20) begin
            tick();
            if (wr_rdy) break;
            n++;
         end
         check("drain_cycles", n, tbl[v].nbeats);
         check("drain_beats", wlog.size(), tbl[v].nbeats);
         for (int k = 0; k < tbl[v].nbeats && k < wlog.size(); k++) begin
            check("drain_addr", wlog[k].addr, tbl[v].addr0 + 32'(4 * k));
            check("drain_we", 32'(wlog[k].we), 32'(tbl[v].we));
            check("drain_data", wlog[k].data,
                  (tbl[v].wtype == T_LINE) ? tbl[v].wdata[127 - 32*k -: 32] : tbl[v].wdata[127:96]);
         end
      end
      do_read(T_WORD, 32'h3004);
      do_read(T_LINE, 32'h2000);
      do_read(T_LINE, 32'h0400);
      do_read(T_BYTE, 32'h0103);

      // Simultaneous write and read to the same line: write wins, read sees new data.
      rd128 = {$urandom, $urandom, $urandom, $urandom};
      ref_write(T_LINE, 32'h2400, 4'h0, rd128);
      push_expected(T_LINE, 32'h2404);
      wr_req = 1'b1; wr_type = T_LINE; wr_addr = 32'h2400; wr_wstrb = 4'h0; wr_data = rd128;
      rd_req = 1'b1; rd_type = T_LINE; rd_addr = 32'h2404;
      @(negedge clk_g);
      check("rd_rdy_vs_wr_req", 32'(rd_rdy), 32'd0);
      tick();
      wr_req = 1'b0;
      finish_read(T_LINE, 32'h2404, n);
      check("rd_blocked_cycles", n, 32'd4);

      // Reset on the second return beat of a line read.
      push_expected(T_LINE, 32'h0800);
      rd_req = 1'b1; rd_type = T_LINE; rd_addr = 32'h0800;
      @(negedge clk_g);
      check("rst_seq_accept", 32'(rd_rdy), 32'd1);
      tick();
      rd_req = 1'b0;
      repeat (3) @(negedge clk_g);
      #2;
      reset = 1'b1;
      #1;
      check("rst_mid_ret_valid", 32'(ret_valid), 32'd0);
      check("rst_mid_mem_en", 32'(mem_en), 32'd0);
      check("rst_mid_ret_last", 32'(ret_last), 32'd0);
      check("rst_mid_wr_rdy", 32'(wr_rdy), 32'd1);
      check("beats_before_reset", exp_q.size(), 32'd2);
      exp_q.delete();
      tick();
      tick();
      reset = 1'b0;
      act = 0;
      repeat (6) begin
         @(negedge clk_g);
         if (ret_valid || mem_en) act++;
      end
      check("activity_after_reset", act, 32'd0);
      tick();
      do_read(T_LINE, 32'h0800);

      // Randomized traffic against the reference memory.
      for (int it = 0; it < 60; it++) begin
         ra = 32'($urandom_range(0, 32'h3FFF));
         rt = type_pick[$urandom_range(0, 3)];
         case ($urandom_range(0, 2))
            0: do_write(rt, ra, 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
            1: do_read(rt, ra);
            default: begin
               do_write(rt, ra, 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
               do_read(type_pick[$urandom_range(0, 3)], ra);
            end
         endcase
         repeat ($urandom_range(0, 2)) tick();
      end
      n = 0;
      while (!wr_rdy && n < 20) begin
         tick();
         n++;
      end
      do_read(T_LINE, 32'h2000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
